// File: rtl/afu_req_arb.sv
// Two-requester arbiter sharing one read and one write AFU request port.
// Round-robin grants, outstanding tracking, response routing by ID bit.
module afu_req_arb #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int MAX_OUT     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  output logic                       done,
  output logic                       idle,
  output logic                       err,
  input  logic [1:0]                 u_rd_valid,
  input  logic [2*ADDR_LMT-1:0]      u_rd_addr,
  input  logic [2*(MDATA-1)-1:0]     u_rd_mdata,
  output logic [1:0]                 u_rd_ready,
  output logic [1:0]                 u_rd_rsp_valid,
  output logic [MDATA-2:0]           u_rd_rsp_mdata,
  output logic [CACHE_WIDTH-1:0]     u_rd_rsp_data,
  input  logic [1:0]                 u_wr_valid,
  input  logic [2*ADDR_LMT-1:0]      u_wr_addr,
  input  logic [2*(MDATA-1)-1:0]     u_wr_mdata,
  input  logic [2*CACHE_WIDTH-1:0]   u_wr_data,
  output logic [1:0]                 u_wr_ready,
  output logic [3:0]                 u_wr_rsp_cnt,
  output logic [ADDR_LMT-1:0]        rd_req_addr,
  output logic [MDATA-1:0]           rd_req_mdata,
  output logic                       rd_req_en,
  input  logic                       rd_req_almostfull,
  input  logic                       rd_rsp_valid,
  input  logic [MDATA-1:0]           rd_rsp_mdata,
  input  logic [CACHE_WIDTH-1:0]     rd_rsp_data,
  output logic [ADDR_LMT-1:0]        wr_req_addr,
  output logic [MDATA-1:0]           wr_req_mdata,
  output logic [CACHE_WIDTH-1:0]     wr_req_data,
  output logic                       wr_req_en,
  input  logic                       wr_req_almostfull,
  input  logic                       wr_rsp0_valid,
  input  logic [MDATA-1:0]           wr_rsp0_mdata,
  input  logic                       wr_rsp1_valid,
  input  logic [MDATA-1:0]           wr_rsp1_mdata,
  output logic [7:0]                 rd_out_cnt,
  output logic [7:0]                 wr_out_cnt
);

  localparam int TW = MDATA - 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0] state;
  logic       rd_ptr, wr_ptr;
  logic       rd_ok, wr_ok;
  logic       rd_gnt, wr_gnt;
  logic       rd_id, wr_id;
  logic [1:0] wr_lanes;
  logic [7:0] rd_nxt, wr_nxt;

  // Saturating update: a response with nothing outstanding leaves 0.
  function automatic logic [7:0] cnt_next(input logic [7:0] cnt,
                                          input logic inc,
                                          input logic [1:0] dec);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {8'd0, inc};
    if (sum < {7'd0, dec}) return 8'd0;
    return 8'(sum - {7'd0, dec});
  endfunction

  always_comb begin
    rd_ok  = (state == RUN) && !rd_req_almostfull
             && (rd_out_cnt < 8'(MAX_OUT));
    rd_gnt = 1'b0;
    rd_id  = rd_ptr;
    if (rd_ok && u_rd_valid[rd_ptr]) begin
      rd_gnt = 1'b1;
    end else if (rd_ok && u_rd_valid[!rd_ptr]) begin
      rd_gnt = 1'b1;
      rd_id  = !rd_ptr;
    end
  end

  always_comb begin
    wr_ok  = (state == RUN) && !wr_req_almostfull
             && (wr_out_cnt < 8'(MAX_OUT));
    wr_gnt = 1'b0;
    wr_id  = wr_ptr;
    if (wr_ok && u_wr_valid[wr_ptr]) begin
      wr_gnt = 1'b1;
    end else if (wr_ok && u_wr_valid[!wr_ptr]) begin
      wr_gnt = 1'b1;
      wr_id  = !wr_ptr;
    end
  end

  assign u_rd_ready = {rd_gnt & rd_id, rd_gnt & !rd_id};
  assign u_wr_ready = {wr_gnt & wr_id, wr_gnt & !wr_id};

  assign u_rd_rsp_valid = {rd_rsp_valid & rd_rsp_mdata[TW],
                           rd_rsp_valid & !rd_rsp_mdata[TW]};
  assign u_rd_rsp_mdata = rd_rsp_mdata[TW-1:0];
  assign u_rd_rsp_data  = rd_rsp_data;

  assign wr_lanes = {1'b0, wr_rsp0_valid} + {1'b0, wr_rsp1_valid};
  assign u_wr_rsp_cnt[1:0] =
    {1'b0, wr_rsp0_valid & !wr_rsp0_mdata[TW]}
    + {1'b0, wr_rsp1_valid & !wr_rsp1_mdata[TW]};
  assign u_wr_rsp_cnt[3:2] =
    {1'b0, wr_rsp0_valid & wr_rsp0_mdata[TW]}
    + {1'b0, wr_rsp1_valid & wr_rsp1_mdata[TW]};

  assign rd_nxt = cnt_next(rd_out_cnt, rd_gnt, {1'b0, rd_rsp_valid});
  assign wr_nxt = cnt_next(wr_out_cnt, wr_gnt, wr_lanes);

  // Drain completes in the cycle the last response retires.
  assign done = (state == DRAIN) && (rd_nxt == 8'd0) && (wr_nxt == 8'd0);
  assign idle = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start) state <= RUN;
        RUN:     if (stop) state <= DRAIN;
        DRAIN:   if (done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_out_cnt <= 8'd0;
      wr_out_cnt <= 8'd0;
      err        <= 1'b0;
    end else begin
      if (rd_gnt) rd_ptr <= !rd_id;
      if (wr_gnt) wr_ptr <= !wr_id;
      rd_out_cnt <= rd_nxt;
      wr_out_cnt <= wr_nxt;
      if ((rd_rsp_valid && rd_out_cnt == 8'd0)
          || ({6'd0, wr_lanes} > wr_out_cnt)) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_req_en    <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
      wr_req_en    <= 1'b0;
      wr_req_addr  <= '0;
      wr_req_mdata <= '0;
      wr_req_data  <= '0;
    end else begin
      rd_req_en <= rd_gnt;
      wr_req_en <= wr_gnt;
      if (rd_gnt) begin
        rd_req_addr  <= u_rd_addr[rd_id*ADDR_LMT +: ADDR_LMT];
        rd_req_mdata <= {rd_id, u_rd_mdata[rd_id*TW +: TW]};
      end
      if (wr_gnt) begin
        wr_req_addr  <= u_wr_addr[wr_id*ADDR_LMT +: ADDR_LMT];
        wr_req_mdata <= {wr_id, u_wr_mdata[wr_id*TW +: TW]};
        wr_req_data  <= u_wr_data[wr_id*CACHE_WIDTH +: CACHE_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_afu_req_arb.sv
// Bench for afu_req_arb: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model.
module tb_afu_req_arb;

  localparam int AW = 20;
  localparam int MW = 14;
  localparam int TW = 13;
  localparam int CW = 512;
  localparam int MO = 8;
  localparam int S_IDLE = 0;
  localparam int S_RUN = 1;
  localparam int S_DRAIN = 2;

  logic clk = 1'b0;
  logic reset, start, stop;
  logic done, idle, err;
  logic [1:0] u_rd_valid, u_rd_ready, u_rd_rsp_valid;
  logic [2*AW-1:0] u_rd_addr, u_wr_addr;
  logic [2*TW-1:0] u_rd_mdata, u_wr_mdata;
  logic [TW-1:0] u_rd_rsp_mdata;
  logic [CW-1:0] u_rd_rsp_data;
  logic [1:0] u_wr_valid, u_wr_ready;
  logic [2*CW-1:0] u_wr_data;
  logic [3:0] u_wr_rsp_cnt;
  logic [AW-1:0] rd_req_addr, wr_req_addr;
  logic [MW-1:0] rd_req_mdata, wr_req_mdata;
  logic rd_req_en, wr_req_en, rd_req_almostfull, wr_req_almostfull;
  logic rd_rsp_valid;
  logic [MW-1:0] rd_rsp_mdata;
  logic [CW-1:0] rd_rsp_data, wr_req_data;
  logic wr_rsp0_valid, wr_rsp1_valid;
  logic [MW-1:0] wr_rsp0_mdata, wr_rsp1_mdata;
  logic [7:0] rd_out_cnt, wr_out_cnt;

  afu_req_arb #(.ADDR_LMT(AW), .MDATA(MW), .CACHE_WIDTH(CW), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .done(done), .idle(idle), .err(err),
    .u_rd_valid(u_rd_valid), .u_rd_addr(u_rd_addr),
    .u_rd_mdata(u_rd_mdata), .u_rd_ready(u_rd_ready),
    .u_rd_rsp_valid(u_rd_rsp_valid), .u_rd_rsp_mdata(u_rd_rsp_mdata),
    .u_rd_rsp_data(u_rd_rsp_data),
    .u_wr_valid(u_wr_valid), .u_wr_addr(u_wr_addr),
    .u_wr_mdata(u_wr_mdata), .u_wr_data(u_wr_data),
    .u_wr_ready(u_wr_ready), .u_wr_rsp_cnt(u_wr_rsp_cnt),
    .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
    .rd_req_en(rd_req_en), .rd_req_almostfull(rd_req_almostfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata),
    .rd_rsp_data(rd_rsp_data),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata),
    .wr_req_data(wr_req_data), .wr_req_en(wr_req_en),
    .wr_req_almostfull(wr_req_almostfull),
    .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata),
    .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
    .rd_out_cnt(rd_out_cnt), .wr_out_cnt(wr_out_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int m_st, m_rd_cnt, m_wr_cnt, m_last_rd, m_last_wr;
  logic m_err;
  logic x_rd_en, x_wr_en;
  logic [AW-1:0] x_rd_addr, x_wr_addr;
  logic [MW-1:0] x_rd_mdata, x_wr_mdata;
  logic [CW-1:0] x_wr_data;

  task automatic chk(input string tag, input logic [CW-1:0] obs,
                     input logic [CW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Requester after the last granted one goes first.
  function automatic int pick(input logic [1:0] v, input int last,
                              input logic af, input int cnt);
    int first;
    if (m_st != S_RUN || af || cnt >= MO) return -1;
    first = (last + 1) % 2;
    if (v[first]) return first;
    if (v[last]) return last;
    return -1;
  endfunction

  function automatic logic [2*CW-1:0] rand_wide();
    logic [2*CW-1:0] d;
    for (int k = 0; k < 2*CW/32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE;
    m_rd_cnt = 0;
    m_wr_cnt = 0;
    m_last_rd = 1;
    m_last_wr = 1;
    m_err = 1'b0;
    x_rd_en = 1'b0;
    x_wr_en = 1'b0;
    x_rd_addr = '0;
    x_wr_addr = '0;
    x_rd_mdata = '0;
    x_wr_mdata = '0;
    x_wr_data = '0;
  endtask

  task automatic clear_inputs();
    start = 0; stop = 0;
    u_rd_valid = 0; u_wr_valid = 0;
    u_rd_addr = 0; u_wr_addr = 0;
    u_rd_mdata = 0; u_wr_mdata = 0; u_wr_data = 0;
    rd_req_almostfull = 0; wr_req_almostfull = 0;
    rd_rsp_valid = 0; rd_rsp_mdata = 0; rd_rsp_data = 0;
    wr_rsp0_valid = 0; wr_rsp0_mdata = 0;
    wr_rsp1_valid = 0; wr_rsp1_mdata = 0;
  endtask

  // Check all outputs mid-cycle, then advance the model one clock.
  task automatic tick();
    int g_rd, g_wr, r_rd, r_wr, n_rd, n_wr, c0, c1;
    logic [1:0] e_rv;
    @(negedge clk);
    g_rd = pick(u_rd_valid, m_last_rd, rd_req_almostfull, m_rd_cnt);
    g_wr = pick(u_wr_valid, m_last_wr, wr_req_almostfull, m_wr_cnt);
    r_rd = rd_rsp_valid ? 1 : 0;
    r_wr = int'(wr_rsp0_valid) + int'(wr_rsp1_valid);
    n_rd = m_rd_cnt + (g_rd >= 0 ? 1 : 0) - r_rd;
    n_wr = m_wr_cnt + (g_wr >= 0 ? 1 : 0) - r_wr;
    if (n_rd < 0) n_rd = 0;
    if (n_wr < 0) n_wr = 0;
    c0 = int'(wr_rsp0_valid && !wr_rsp0_mdata[TW])
       + int'(wr_rsp1_valid && !wr_rsp1_mdata[TW]);
    c1 = r_wr - c0;
    e_rv = !rd_rsp_valid ? 2'b00 : (rd_rsp_mdata[TW] ? 2'b10 : 2'b01);
    chk("rd_ready", u_rd_ready, g_rd < 0 ? 0 : 1 << g_rd);
    chk("wr_ready", u_wr_ready, g_wr < 0 ? 0 : 1 << g_wr);
    chk("rd_rsp_valid", u_rd_rsp_valid, e_rv);
    chk("rd_rsp_mdata", u_rd_rsp_mdata, rd_rsp_mdata[TW-1:0]);
    chk("rd_rsp_data", u_rd_rsp_data, rd_rsp_data);
    chk("wr_rsp_cnt", u_wr_rsp_cnt, (c1 << 2) | c0);
    chk("done", done, m_st == S_DRAIN && n_rd == 0 && n_wr == 0);
    chk("idle", idle, m_st == S_IDLE);
    chk("err", err, m_err);
    chk("rd_out_cnt", rd_out_cnt, m_rd_cnt);
    chk("wr_out_cnt", wr_out_cnt, m_wr_cnt);
    chk("rd_req_en", rd_req_en, x_rd_en);
    chk("rd_req_addr", rd_req_addr, x_rd_addr);
    chk("rd_req_mdata", rd_req_mdata, x_rd_mdata);
    chk("wr_req_en", wr_req_en, x_wr_en);
    chk("wr_req_addr", wr_req_addr, x_wr_addr);
    chk("wr_req_mdata", wr_req_mdata, x_wr_mdata);
    chk("wr_req_data", wr_req_data, x_wr_data);
    if (!reset) begin
      if (r_rd > m_rd_cnt || r_wr > m_wr_cnt) m_err = 1'b1;
      x_rd_en = (g_rd >= 0);
      x_wr_en = (g_wr >= 0);
      if (g_rd >= 0) begin
        x_rd_addr = u_rd_addr[g_rd*AW +: AW];
        x_rd_mdata = {g_rd[0], u_rd_mdata[g_rd*TW +: TW]};
        m_last_rd = g_rd;
      end
      if (g_wr >= 0) begin
        x_wr_addr = u_wr_addr[g_wr*AW +: AW];
        x_wr_mdata = {g_wr[0], u_wr_mdata[g_wr*TW +: TW]};
        x_wr_data = u_wr_data[g_wr*CW +: CW];
        m_last_wr = g_wr;
      end
      if (m_st == S_IDLE && start) m_st = S_RUN;
      else if (m_st == S_RUN && stop) m_st = S_DRAIN;
      else if (m_st == S_DRAIN && n_rd == 0 && n_wr == 0) m_st = S_IDLE;
      m_rd_cnt = n_rd;
      m_wr_cnt = n_wr;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    model_reset();
    #1;
    chk("async_rst_cnt", rd_out_cnt, 0);
    chk("async_rst_en", rd_req_en, 0);
    tick();
    reset = 0;
  endtask

  initial begin
    logic [1:0] order [4];
    logic id_seq [4];
    order = '{2'b01, 2'b10, 2'b01, 2'b10};
    id_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
    reset = 1;
    clear_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_idle", idle, 1);

    start = 1; tick(); start = 0;

    // Both requesters contend: alternating grants, tagged by ID.
    u_rd_valid = 2'b11;
    u_rd_addr = 40'h12345_abcde;
    u_rd_mdata = {13'h1aaa, 13'h0555};
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_order", u_rd_ready, order[i]);
      tick();
      chk("rr_en", rd_req_en, 1);
      chk("rr_id", rd_req_mdata[TW], id_seq[i]);
    end

    // Fill to the outstanding limit.
    for (int i = 0; i < 4; i++) tick();
    chk("max_cnt", rd_out_cnt, 8);
    chk("max_block", u_rd_ready, 0);
    tick();
    rd_rsp_valid = 1;
    rd_rsp_mdata = 14'h0007;
    #1 chk("max_same_cycle", u_rd_ready, 0);
    tick();
    rd_rsp_valid = 0;
    #1 chk("max_regrant", u_rd_ready, 2'b01);
    tick();
    u_rd_valid = 0;

    // Return 6 of 8, then drain the last two.
    rd_rsp_valid = 1;
    for (int i = 0; i < 6; i++) begin
      rd_rsp_mdata = 14'(i * 1000 + 4096 * (i % 2) * 2);
      rd_rsp_data = rand_wide()[CW-1:0];
      tick();
    end
    rd_rsp_valid = 0;
    chk("pre_stop_cnt", rd_out_cnt, 2);
    stop = 1; tick(); stop = 0;
    rd_rsp_valid = 1;
    rd_rsp_mdata = 14'h2001;
    #1 chk("drain_first", done, 0);
    tick();
    #1 chk("drain_last", done, 1);
    tick();
    rd_rsp_valid = 0;
    #1 chk("drain_idle", idle, 1);
    chk("drain_done_off", done, 0);
    tick();

    // Two write lanes complete for requester 1 in one cycle.
    start = 1; tick(); start = 0;
    u_wr_valid = 2'b01;
    u_wr_addr = 40'h00000_0beef;
    u_wr_mdata = {13'h0, 13'h0123};
    u_wr_data = rand_wide();
    for (int i = 0; i < 3; i++) tick();
    u_wr_valid = 0;
    chk("wr_three", wr_out_cnt, 3);
    wr_rsp0_valid = 1; wr_rsp0_mdata = 14'h2010;
    wr_rsp1_valid = 1; wr_rsp1_mdata = 14'h2011;
    #1 chk("wr_both_lanes", u_wr_rsp_cnt, 4'b1000);
    tick();
    wr_rsp1_valid = 0;
    wr_rsp0_mdata = 14'h0001;
    chk("wr_cnt_after", wr_out_cnt, 1);
    tick();
    wr_rsp0_valid = 0;

    // Almost-full holds off grants until it drops.
    u_rd_valid = 2'b01;
    rd_req_almostfull = 1;
    #1 chk("af_block", u_rd_ready, 0);
    tick(); tick();
    rd_req_almostfull = 0;
    #1 chk("af_release", u_rd_ready, 2'b01);
    tick();
    u_rd_valid = 0;
    rd_rsp_valid = 1; tick(); rd_rsp_valid = 0;

    // Random traffic with legal responses.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(9) == 0);
      stop = ($urandom_range(19) == 0);
      u_rd_valid = 2'($urandom());
      u_wr_valid = 2'($urandom());
      u_rd_addr = 40'({$urandom(), $urandom()});
      u_wr_addr = 40'({$urandom(), $urandom()});
      u_rd_mdata = 26'($urandom());
      u_wr_mdata = 26'($urandom());
      u_wr_data = rand_wide();
      rd_req_almostfull = ($urandom_range(3) == 0);
      wr_req_almostfull = ($urandom_range(3) == 0);
      rd_rsp_valid = (m_rd_cnt > 0) && $urandom_range(1) == 1;
      rd_rsp_mdata = 14'($urandom());
      rd_rsp_data = rand_wide()[CW-1:0];
      wr_rsp0_valid = (m_wr_cnt > 0) && $urandom_range(1) == 1;
      wr_rsp1_valid = (m_wr_cnt > int'(wr_rsp0_valid))
                      && $urandom_range(1) == 1;
      wr_rsp0_mdata = 14'($urandom());
      wr_rsp1_mdata = 14'($urandom());
      tick();
    end

    // Reset mid-operation, then a stray response must flag err.
    do_reset();
    rd_rsp_valid = 1;
    rd_rsp_mdata = 14'h0042;
    tick();
    rd_rsp_valid = 0;
    chk("err_set", err, 1);
    chk("err_cnt_zero", rd_out_cnt, 0);
    tick(); tick();
    chk("err_sticky", err, 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
